// File: rtl/toy_pkg.sv
// Shared types, widths and address-split helpers for the RISC_TOY instruction cache.
package toy_pkg;

  localparam int unsigned WORD_AW = 30;
  localparam int unsigned INSTR_W = 32;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StFill
  } state_e;

  // Word-offset width inside a line.
  function automatic int unsigned off_w(int unsigned words);
    return $clog2(words);
  endfunction

  // Line-index width.
  function automatic int unsigned idx_w(int unsigned lines);
    return $clog2(lines);
  endfunction

  // Tag width: whatever word-address bits remain above index and offset.
  function automatic int unsigned tag_w(int unsigned lines, int unsigned words);
    return WORD_AW - $clog2(lines) - $clog2(words);
  endfunction

endpackage

// File: rtl/toy_icache_if.sv
// Fetch-side and refill-side bus of the instruction cache.
interface toy_icache_if;
  import toy_pkg::*;

  logic               ireq;
  logic [WORD_AW-1:0] iaddr;
  logic [INSTR_W-1:0] instr;
  logic               istall;
  logic               flush;
  logic               mreq;
  logic [WORD_AW-1:0] maddr;
  logic               mack;
  logic               mvalid;
  logic [INSTR_W-1:0] mrdata;

  // The cache itself.
  modport slave (
    input  ireq, iaddr, flush, mack, mvalid, mrdata,
    output instr, istall, mreq, maddr
  );

  // Core plus backing memory, as seen from outside the cache.
  modport master (
    output ireq, iaddr, flush, mack, mvalid, mrdata,
    input  instr, istall, mreq, maddr
  );

endinterface

// File: rtl/toy_icache_tags.sv
// Valid/tag array: lookup compare, tag write on refill completion, flush-all.
module toy_icache_tags #(
  parameter int unsigned LINES = 16,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned TAG_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] lookup_idx,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             lookup_hit,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_valid,
  input  logic             flush_all
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [LINES];

  assign lookup_hit = valid_q[lookup_idx] & (tag_q[lookup_idx] == lookup_tag);

  // Valid bits: reset and flush clear everything; flush beats a same-edge line install.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (flush_all) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= wr_valid;
    end
  end

  // Tags carry no reset; they are meaningless until the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx] <= wr_tag;
    end
  end

endmodule

// File: rtl/toy_icache.sv
// Direct-mapped read-only instruction cache: combinational hit path, single-line refill FSM.
module toy_icache
  import toy_pkg::*;
#(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 4
) (
  input logic        clk,
  input logic        rst,
  toy_icache_if.slave bus
);

  localparam int unsigned OFF_W  = off_w(WORDS);
  localparam int unsigned IDX_W  = idx_w(LINES);
  localparam int unsigned TAG_W  = tag_w(LINES, WORDS);
  localparam int unsigned LINE_W = WORD_AW - OFF_W;

  logic [OFF_W-1:0]   req_off;
  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic [LINE_W-1:0]  line_q;
  logic [IDX_W-1:0]   fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  state_e             state_q;
  logic [OFF_W-1:0]   cnt_q;
  logic               pend_q;
  logic               mreq_q;
  logic [WORD_AW-1:0] maddr_q;
  logic               tag_hit;
  logic               hit;
  logic               beat;
  logic               last_beat;
  logic [INSTR_W-1:0] data_q [LINES*WORDS];

  assign req_off  = bus.iaddr[OFF_W-1:0];
  assign req_idx  = bus.iaddr[OFF_W +: IDX_W];
  assign req_tag  = bus.iaddr[WORD_AW-1 -: TAG_W];
  assign fill_idx = line_q[IDX_W-1:0];
  assign fill_tag = line_q[LINE_W-1 -: TAG_W];

  // Hits are only served from IDLE; reset forces the fetch side quiet.
  assign hit       = bus.ireq & tag_hit & (state_q == StIdle) & ~rst;
  assign beat      = (state_q == StFill) & bus.mvalid;
  assign last_beat = beat & (cnt_q == OFF_W'(WORDS - 1));

  assign bus.istall = rst | (bus.ireq & ~hit);
  assign bus.instr  = hit ? data_q[{req_idx, req_off}] : '0;
  assign bus.mreq   = mreq_q;
  assign bus.maddr  = maddr_q;

  toy_icache_tags #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_tags (
    .clk        (clk),
    .rst        (rst),
    .lookup_idx (req_idx),
    .lookup_tag (req_tag),
    .lookup_hit (tag_hit),
    .wr_en      (last_beat & ~rst),
    .wr_idx     (fill_idx),
    .wr_tag     (fill_tag),
    // A flush seen during the refill, or on its final edge, leaves the line invalid.
    .wr_valid   (~pend_q & ~bus.flush),
    .flush_all  (bus.flush)
  );

  // Data array: each refill beat lands at the latched line, ascending word order.
  always_ff @(posedge clk) begin
    if (beat && !rst) begin
      data_q[{fill_idx, cnt_q}] <= bus.mrdata;
    end
  end

  // Refill FSM with registered memory-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      mreq_q  <= 1'b0;
      maddr_q <= '0;
      line_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.ireq && !tag_hit) begin
            line_q  <= bus.iaddr[WORD_AW-1:OFF_W];
            maddr_q <= {bus.iaddr[WORD_AW-1:OFF_W], {OFF_W{1'b0}}};
            cnt_q   <= '0;
            mreq_q  <= 1'b1;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (bus.flush) pend_q <= 1'b1;
          if (bus.mack) begin
            mreq_q  <= 1'b0;
            state_q <= StFill;
          end
        end
        StFill: begin
          if (bus.flush) pend_q <= 1'b1;
          if (bus.mvalid) begin
            cnt_q <= cnt_q + 1'b1;
            if (last_beat) begin
              pend_q  <= 1'b0;
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_toy_icache.sv
// Directed bench for toy_icache: vector table plus hand-timed flush/reset sequences.
module tb_toy_icache;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  toy_icache_if bus ();

  toy_icache #(
    .LINES (16),
    .WORDS (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Backing-memory behaviour knobs and observations.
  int          ack_delay = 0;
  int          beat_gap  = 0;
  logic [29:0] last_base = '0;
  int          req_seen  = 0;

  typedef struct {
    logic [29:0] addr;
    int          stalls;
    logic [31:0] instr;
    logic [29:0] maddr;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [31:0] mem_word(logic [29:0] a);
    if (a >= 30'h4 && a < 30'h8) return 32'hA0 + 32'(a - 30'h4);
    return 32'hC000_0000 | {2'b00, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present a fetch and count stall cycles until it is served (bounded).
  task automatic fetch(input logic [29:0] a, output int stalls, output logic [31:0] data);
    @(negedge clk);
    bus.ireq  = 1'b1;
    bus.iaddr = a;
    stalls    = 0;
    #2;
    while (bus.istall && stalls < 200) begin
      stalls++;
      @(negedge clk);
      #2;
    end
    data = bus.instr;
  endtask

  // Backing memory: ack after ack_delay REQ cycles, then WORDS beats separated by beat_gap.
  initial begin
    int          ms;
    int          ack_wait;
    int          bcnt;
    int          gap_wait;
    logic [29:0] base;
    ms = 0; ack_wait = 0; bcnt = 0; gap_wait = 0; base = '0;
    bus.mack = 1'b0; bus.mvalid = 1'b0; bus.mrdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ms = 0;
        bus.mack = 1'b0; bus.mvalid = 1'b0; bus.mrdata = '0;
      end else begin
        case (ms)
          0: begin
            bus.mvalid = 1'b0;
            bus.mack   = 1'b0;
            if (bus.mreq) begin
              base = bus.maddr;
              last_base = base;
              req_seen++;
              if (ack_delay == 0) begin
                bus.mack = 1'b1; ms = 2; bcnt = 0; gap_wait = 0;
              end else begin
                ack_wait = ack_delay; ms = 1;
              end
            end
          end
          1: begin
            ack_wait--;
            if (ack_wait == 0) begin
              bus.mack = 1'b1; ms = 2; bcnt = 0; gap_wait = 0;
            end
          end
          2: begin
            bus.mack = 1'b0;
            if (gap_wait > 0) begin
              bus.mvalid = 1'b0;
              gap_wait--;
            end else begin
              bus.mvalid = 1'b1;
              bus.mrdata = mem_word(base + 30'(bcnt));
              bcnt++;
              gap_wait = beat_gap;
              if (bcnt == 4) ms = 3;
            end
          end
          default: begin
            bus.mvalid = 1'b0;
            ms = 0;
          end
        endcase
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          st;
    logic [31:0] d;

    vecs[0] = '{addr: 30'h04, stalls: 6, instr: 32'h0000_00A0, maddr: 30'h04};
    vecs[1] = '{addr: 30'h05, stalls: 0, instr: 32'h0000_00A1, maddr: 30'h04};
    vecs[2] = '{addr: 30'h06, stalls: 0, instr: 32'h0000_00A2, maddr: 30'h04};
    vecs[3] = '{addr: 30'h07, stalls: 0, instr: 32'h0000_00A3, maddr: 30'h04};
    vecs[4] = '{addr: 30'h44, stalls: 6, instr: 32'hC000_0044, maddr: 30'h44};
    vecs[5] = '{addr: 30'h04, stalls: 6, instr: 32'h0000_00A0, maddr: 30'h04};
    vecs[6] = '{addr: 30'h10, stalls: 6, instr: 32'hC000_0010, maddr: 30'h10};
    vecs[7] = '{addr: 30'h13, stalls: 0, instr: 32'hC000_0013, maddr: 30'h10};
    vecs[8] = '{addr: 30'h05, stalls: 0, instr: 32'h0000_00A1, maddr: 30'h04};

    rst = 1'b1; bus.ireq = 1'b0; bus.iaddr = '0; bus.flush = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check("rst_istall", 32'(bus.istall), 32'd1);
    check("rst_mreq",   32'(bus.mreq),   32'd0);
    check("rst_maddr",  32'(bus.maddr),  32'd0);
    check("rst_instr",  bus.instr,       32'd0);
    @(negedge clk);
    rst = 1'b0;

    // No request with every line invalid: idle and silent.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.iaddr = 30'(4 + i);
      #2;
      check("idle_istall", 32'(bus.istall), 32'd0);
      check("idle_instr",  bus.instr,       32'd0);
      check("idle_mreq",   32'(bus.mreq),   32'd0);
    end
    check("idle_no_req", 32'(req_seen), 32'd0);

    // Cold miss, hits within the line, conflict eviction and re-miss.
    for (int i = 0; i < 9; i++) begin
      fetch(vecs[i].addr, st, d);
      check($sformatf("vec%0d_stalls", i), 32'(st), 32'(vecs[i].stalls));
      check($sformatf("vec%0d_instr", i), d, vecs[i].instr);
      if (vecs[i].stalls > 0) check($sformatf("vec%0d_maddr", i), {2'b00, last_base},
                                    {2'b00, vecs[i].maddr});
    end

    // Slow memory: MACK after 3 REQ cycles, 2 idle cycles between beats.
    ack_delay = 3; beat_gap = 2;
    fetch(30'h20, st, d);
    check("slow_stalls", 32'(st), 32'd15);
    check("slow_instr",  d,       32'hC000_0020);
    check("slow_maddr",  {2'b00, last_base}, 32'h20);
    fetch(30'h22, st, d);
    check("slow_hit_stalls", 32'(st), 32'd0);
    check("slow_hit_instr",  d,       32'hC000_0022);
    ack_delay = 0; beat_gap = 0;

    // FLUSH on the edge of beat 2: fill completes, line and older lines end invalid.
    @(negedge clk);
    bus.ireq = 1'b1; bus.iaddr = 30'h30;
    repeat (4) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    @(negedge clk);
    bus.ireq = 1'b0;
    #2;
    check("flush_fill_done_mreq", 32'(bus.mreq),   32'd0);
    check("flush_fill_done_stall", 32'(bus.istall), 32'd0);
    fetch(30'h30, st, d);
    check("flush_same_stalls", 32'(st), 32'd6);
    check("flush_same_instr",  d,       32'hC000_0030);
    fetch(30'h05, st, d);
    check("flush_old_stalls", 32'(st), 32'd6);
    check("flush_old_instr",  d,       32'h0000_00A1);

    // FLUSH on the same edge as the final beat.
    @(negedge clk);
    bus.ireq = 1'b1; bus.iaddr = 30'h34;
    repeat (5) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0; bus.ireq = 1'b0;
    fetch(30'h34, st, d);
    check("flush_last_stalls", 32'(st), 32'd6);
    check("flush_last_instr",  d,       32'hC000_0034);

    // Reset in the middle of a refill.
    @(negedge clk);
    bus.ireq = 1'b1; bus.iaddr = 30'h50;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #2;
    check("midrst_istall0", 32'(bus.istall), 32'd1);
    @(negedge clk);
    #2;
    check("midrst_mreq",   32'(bus.mreq),   32'd0);
    check("midrst_istall", 32'(bus.istall), 32'd1);
    check("midrst_instr",  bus.instr,       32'd0);
    @(negedge clk);
    rst = 1'b0; bus.ireq = 1'b0;
    fetch(30'h50, st, d);
    check("postrst_stalls", 32'(st), 32'd6);
    check("postrst_instr",  d,       32'hC000_0050);
    check("postrst_maddr",  {2'b00, last_base}, 32'h50);
    fetch(30'h53, st, d);
    check("postrst_hit_stalls", 32'(st), 32'd0);
    check("postrst_hit_instr",  d,       32'hC000_0053);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/toy_icache.md
# toy_icache

Direct-mapped, read-only instruction cache between the RISC_TOY fetch stage and a slower backing instruction memory. It answers the core's word-addressed fetch (IREQ/IADDR/INSTR) combinationally on a hit. On a miss it asserts ISTALL and refills one full line over a request/acknowledge/valid handshake. The core holds IADDR and freezes PC/FD while ISTALL is high.

## Interface
- LINES, 16, number of lines; power of two, at least 2.
- WORDS, 4, 32-bit words per line; power of two, at least 2.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- IREQ  in  1  fetch request from the core.
- IADDR  in  30  fetch word address.
- INSTR  out  32  instruction word; valid when IREQ=1 and ISTALL=0, otherwise 0.
- ISTALL  out  1  fetch not served this cycle; core must hold IADDR.
- FLUSH  in  1  one-cycle pulse that invalidates all lines.
- MREQ  out  1  line refill request to backing memory.
- MADDR  out  30  line-aligned word address of the refill (offset bits = 0).
- MACK  in  1  memory accepts the request; sampled only in state REQ.
- MVALID  in  1  one refill data beat; sampled only in state FILL.
- MRDATA  in  32  refill data, beats in ascending word order.

## Operation
- Address split:
  - OFF = log2(WORDS) bits, IADDR[OFF-1:0].
  - IDX = log2(LINES) bits, next above OFF.
  - TAG = remaining upper bits (24 bits at the default sizes).
- Storage: valid[LINES], tag[LINES], data[LINES×WORDS].
  - Only valid is reset.
  - Tag and data contents are undefined after reset.
- hit = IREQ & valid[idx] & tag[idx]==TAG & state==IDLE.
- ISTALL = RST | (IREQ & ~hit). It is a combinational output.
- INSTR = hit ? data[idx][off] : 0.
- FSM:
  - IDLE: on IREQ & ~hit, latch the line address and clear the beat counter, then go to REQ.
  - REQ: MREQ=1, MADDR stable. On MACK, go to FILL.
  - FILL: on each MVALID, write MRDATA to data[idx][cnt] and increment cnt. On the beat with cnt==WORDS-1:
    - write tag[idx];
    - set valid[idx] unless a flush is pending;
    - clear the pending flag;
    - go to IDLE.
- FLUSH:
  - In IDLE, clears all valid bits next edge.
  - In REQ or FILL, clears all valid bits and sets the pending flag. The in-flight refill still consumes all WORDS beats but leaves its line invalid.
  - FLUSH on the same edge as the final beat: the line ends invalid.
- The refill uses the latched address. An IADDR change during the stall does not alter the fill. After return to IDLE, lookup uses the current IADDR.
- IREQ=0 in IDLE: no state change, ISTALL=0.

## Timing
- Reset values:
  - MREQ=0, MADDR=0, INSTR=0.
  - ISTALL=1 while RST is high.
  - state=IDLE, all valid=0, cnt=0, pending flush=0.
- Reset mid-refill: abort to IDLE and drop MREQ next cycle. Partial line stays invalid. Backing memory must be reset with the cache.
- Hit latency: 0 cycles (combinational).
- Miss, cycle by cycle (0 = miss detected):
  - REQ from cycle 1; MACK can arrive in the first REQ cycle.
  - FILL from the cycle after MACK.
  - IDLE, and a hit, the cycle after the last beat.
- Minimum miss penalty with MACK and MVALID immediate: 6 stall cycles (cycles 0–5) at WORDS=4.
- MVALID gaps are allowed. MVALID outside FILL is ignored. MACK outside REQ is ignored.
- One refill is outstanding at most.

## Structure
- Shared package toy_pkg holds:
  - state enum {IDLE, REQ, FILL};
  - WORD_AW=30 and INSTR_W=32;
  - functions deriving OFF, IDX and TAG widths from LINES and WORDS.
- Sub-module toy_icache_tags: valid/tag array with lookup compare, tag write, and flush-all. Data array and FSM stay in the top.

## Test plan
- Cold miss at 0x0000_0004 with immediate MACK and beats 0xA0..0xA3:
  - MADDR=0x4;
  - ISTALL high for 6 cycles;
  - then INSTR=0xA0 (offset 0);
  - IADDR 0x5..0x7 hit with 0 stall, giving 0xA1..0xA3.
- Conflict: fill index 1 from 0x04, then fetch 0x44 (same idx, new tag):
  - miss, MADDR=0x44;
  - afterwards 0x04 misses again.
- MVALID gaps of 2 cycles between beats, and MACK delayed 3 cycles: correct data, and ISTALL ends exactly 1 cycle after the last beat.
- FLUSH during FILL beat 2:
  - the fill completes;
  - the next fetch of the same address misses;
  - a previously valid line also misses.
- RST asserted mid-FILL:
  - MREQ=0 and ISTALL=1 during reset;
  - after release, the same address misses and refills cleanly.
- IREQ=0 with all lines invalid: ISTALL=0, INSTR=0, MREQ never asserted.
